muladd_seq: RTL and testbench

Sequential shift-add multiply-accumulate unit computing result = multiplicand × multiplier + addend, one multiplier bit per clock. It is the inverse companion to the team's repeated-subtraction divider. Fed a quotient, divisor and remainder, it reconstructs the dividend, so it serves both general multiplication and divider self-check paths. It replaces enable-level control with a valid/ready handshake on both input and output.

---
 rtl/muladd_seq_pkg.sv | 19 +
 rtl/muladd_seq.sv | 86 ++++++++
 tb/tb_muladd_seq.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/muladd_seq_pkg.sv
// Shared types and constants for the shift-add multiply-accumulate unit.
// The default width is common with the repeated-subtraction divider.
package muladd_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 32;

   function automatic int cnt_width(input int w);
      return $clog2(w) + 1;
   endfunction

   localparam int CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/muladd_seq.sv
// Sequential multiply-accumulate: result = multiplicand * multiplier + addend,
// one multiplier bit per clock, valid/ready on both sides.
module muladd_seq
   import muladd_seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   input  logic [WIDTH-1:0]   addend,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] result,
   output logic               busy
);

   localparam int CW = cnt_width(WIDTH);

   state_t             state;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [CW-1:0]      cnt;
   logic               last;

   assign last   = (cnt == CW'(WIDTH - 1));
   assign result = acc;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         acc       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         cnt       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  acc      <= {{WIDTH{1'b0}}, addend};
                  mcand    <= {{WIDTH{1'b0}}, multiplicand};
                  mplier   <= multiplier;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= CALC;
               end
            end
            CALC: begin
               if (mplier[0])
                  acc <= acc + mcand;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 1'b1;
               // fixed WIDTH-cycle run, no early exit on zero multiplier
               if (last) begin
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               busy      <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muladd_seq.sv
// Bench for muladd_seq: behavioural timing/arithmetic model plus
// directed and random operations.
module tb_muladd_seq;

   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rstn = 1'b0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [W-1:0]   a_i = '0;
   logic [W-1:0]   b_i = '0;
   logic [W-1:0]   c_i = '0;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [2*W-1:0] result;
   logic           busy;

   int npass = 0;
   int ntot  = 0;

   muladd_seq #(.WIDTH(W)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .multiplicand (a_i),
      .multiplier   (b_i),
      .addend       (c_i),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .result       (result),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [2*W-1:0] act,
                      input logic [2*W-1:0] exp);
      ntot++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Model: an accepted operation is busy for W cycles, then presents
   // a*b+c until out_ready is seen.
   bit             m_busy  = 1'b0;
   bit             m_valid = 1'b0;
   int             m_left  = 0;
   logic [2*W-1:0] m_res   = '0;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_busy  <= 1'b0;
         m_valid <= 1'b0;
         m_left  <= 0;
      end else if (!m_busy) begin
         if (in_valid) begin
            m_busy <= 1'b1;
            m_left <= W;
            m_res  <= {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i}
                      + {{W{1'b0}}, c_i};
         end
      end else if (!m_valid) begin
         if (m_left == 1) m_valid <= 1'b1;
         m_left <= m_left - 1;
      end else if (out_ready) begin
         m_busy  <= 1'b0;
         m_valid <= 1'b0;
      end
   end

   always @(negedge clk) begin
      chk("in_ready", {63'd0, in_ready}, {63'd0, !m_busy});
      chk("busy", {63'd0, busy}, {63'd0, m_busy});
      chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
      if (m_valid) chk("result", result, m_res);
   end

   task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] c, input int hold,
                     input bit tog, input int rst_at,
                     output logic [2*W-1:0] r, output int lat);
      int k;
      r   = '0;
      lat = 0;
      out_ready = (hold == 0);
      k = 0;
      @(negedge clk);
      while (!in_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("accept_wait", {63'd0, in_ready}, 64'd1);
      a_i = a; b_i = b; c_i = c;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      while (lat < 100) begin
         @(posedge clk);
         lat++;
         #1;
         if (rst_at != 0 && lat == rst_at) begin
            rstn = 1'b0;
            #1;
            chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
            chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
            chk("rst_busy", {63'd0, busy}, 64'd0);
            chk("rst_result", result, 64'd0);
            @(negedge clk);
            #2;
            rstn = 1'b1;
            out_ready = 1'b0;
            return;
         end
         if (out_valid) begin
            in_valid = 1'b0;
            break;
         end
         chk("calc_in_ready", {63'd0, in_ready}, 64'd0);
         if (tog) begin
            a_i = $urandom; b_i = $urandom; c_i = $urandom;
            in_valid = 1'($urandom);
         end
      end
      r = result;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         a_i = $urandom; b_i = $urandom; c_i = $urandom;
         in_valid = 1'($urandom);
         chk("hold_valid", {63'd0, out_valid}, 64'd1);
         chk("hold_result", result, r);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   logic [2*W-1:0] r;
   int             lat;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
      chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
      chk("reset_busy", {63'd0, busy}, 64'd0);
      chk("reset_result", result, 64'd0);
      rstn = 1'b1;

      op(32'd14, 32'd7, 32'd2, 0, 1'b0, 0, r, lat);
      chk("div_roundtrip", r, 64'd100);
      chk("latency", 64'(lat), 64'd32);

      op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, 0, r, lat);
      chk("max_operands", r, 64'hFFFF_FFFF_0000_0000);

      op(32'd0, 32'h1234_5678, 32'd0, 0, 1'b0, 0, r, lat);
      chk("zero_result", r, 64'd0);
      chk("zero_latency", 64'(lat), 64'd32);

      op(32'd6, 32'd5, 32'd1, 10, 1'b0, 0, r, lat);
      chk("stall_result", r, 64'd31);

      op(32'd3, 32'd3, 32'd0, 0, 1'b1, 0, r, lat);
      chk("toggle_result", r, 64'd9);

      op(32'd9, 32'd9, 32'd0, 0, 1'b0, 15, r, lat);
      op(32'd2, 32'd2, 32'd1, 0, 1'b0, 0, r, lat);
      chk("after_reset", r, 64'd5);

      for (int n = 0; n < 20; n++) begin
         logic [W-1:0] a, b, c;
         a = $urandom; b = $urandom; c = $urandom;
         if (n % 5 == 0) b = '1;
         op(a, b, c, int'($urandom_range(0, 3)), 1'($urandom), 0, r, lat);
         chk("rand_result", r, {{W{1'b0}}, a} * {{W{1'b0}}, b}
                               + {{W{1'b0}}, c});
         chk("rand_latency", 64'(lat), 64'd32);
      end

      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
